// File: rtl/cdc_event_sender.sv
// Source-side request/ack front end for the clkHI->clkLOW bit synchronizer.
// Launches one held request level per event and queues events that arrive mid-handshake.
module cdc_event_sender #(
  parameter int CNT_W = 4
) (
  input  logic             clkHI,
  input  logic             rst,
  input  logic             pulse_in,
  input  logic             ack_in,
  input  logic             clr_ovf,
  output logic             req_out,
  output logic             busy,
  output logic [CNT_W-1:0] pending,
  output logic             overflow,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE,
    REQ_HI,
    REQ_LO
  } state_t;

  localparam logic [CNT_W-1:0] PEND_MAX = '1;

  state_t           state_q, state_d;
  logic             req_q, req_d;
  logic [CNT_W-1:0] pending_q, pending_d;
  logic             overflow_q, overflow_d;
  logic             done_q, done_d;
  logic             ack_s1_q, ack_s2_q;
  logic [CNT_W:0]   eff;
  logic             ovf_set;

  assign eff = {1'b0, pending_q} + (CNT_W+1)'(pulse_in);

  always_comb begin
    state_d   = state_q;
    req_d     = req_q;
    pending_d = pending_q;
    done_d    = 1'b0;
    ovf_set   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (eff != '0) begin
          state_d   = REQ_HI;
          req_d     = 1'b1;
          pending_d = CNT_W'(eff - (CNT_W+1)'(1));
        end
      end
      REQ_HI: begin
        if (ack_s2_q) begin
          state_d = REQ_LO;
          req_d   = 1'b0;
        end
      end
      REQ_LO: begin
        if (!ack_s2_q) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        req_d   = 1'b0;
      end
    endcase
    // In IDLE any pulse is absorbed by the launch, so only busy states queue.
    if (state_q != IDLE && pulse_in) begin
      if (pending_q != PEND_MAX) begin
        pending_d = pending_q + CNT_W'(1);
      end else begin
        ovf_set = 1'b1;
      end
    end
    overflow_d = ovf_set | (overflow_q & ~clr_ovf);
  end

  always_ff @(posedge clkHI or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      req_q      <= 1'b0;
      pending_q  <= '0;
      overflow_q <= 1'b0;
      done_q     <= 1'b0;
      ack_s1_q   <= 1'b0;
      ack_s2_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      req_q      <= req_d;
      pending_q  <= pending_d;
      overflow_q <= overflow_d;
      done_q     <= done_d;
      ack_s1_q   <= ack_in;
      ack_s2_q   <= ack_s1_q;
    end
  end

  assign req_out  = req_q;
  assign busy     = (state_q != IDLE);
  assign pending  = pending_q;
  assign overflow = overflow_q;
  assign done     = done_q;

endmodule

// File: tb/tb_cdc_event_sender.sv
// Bench for cdc_event_sender: event-level reference model with a done scoreboard.
// Directed scenarios followed by randomized pulses against a looped-back ack.
module tb_cdc_event_sender;
  localparam int CNT_W = 4;
  localparam int MAXP  = (1 << CNT_W) - 1;

  logic             clkHI = 1'b0;
  logic             rst = 1'b0;
  logic             pulse_in = 1'b0;
  logic             ack_in = 1'b0;
  logic             clr_ovf = 1'b0;
  logic             req_out, busy, overflow, done;
  logic [CNT_W-1:0] pending;

  cdc_event_sender #(.CNT_W(CNT_W)) dut (
    .clkHI   (clkHI),
    .rst     (rst),
    .pulse_in(pulse_in),
    .ack_in  (ack_in),
    .clr_ovf (clr_ovf),
    .req_out (req_out),
    .busy    (busy),
    .pending (pending),
    .overflow(overflow),
    .done    (done)
  );

  always #5 clkHI = ~clkHI;

  int tests = 0;
  int fails = 0;
  int n_done = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: phase 0 = idle, 1 = waiting for ack, 2 = waiting for ack release.
  int m_pend, m_phase, m_req, m_ovf, m_done;
  int m_a2, m_eff, m_set, seq;
  bit hist[$];
  int exp_q[$];

  always @(posedge clkHI or negedge rst) begin
    if (!rst) begin
      m_pend = 0; m_phase = 0; m_req = 0; m_ovf = 0; m_done = 0;
      hist.delete();
      hist.push_back(1'b0);
      hist.push_back(1'b0);
      exp_q.delete();
    end else begin
      m_a2 = int'(hist[1]);
      hist.push_front(ack_in);
      void'(hist.pop_back());
      m_eff = m_pend + int'(pulse_in);
      m_set = 0;
      m_done = 0;
      if (m_phase == 0) begin
        if (m_eff > 0) begin
          m_phase = 1;
          m_req = 1;
          m_pend = m_eff - 1;
          if (pulse_in) exp_q.push_back(seq++);
        end
      end else begin
        if (pulse_in) begin
          if (m_pend < MAXP) begin
            m_pend++;
            exp_q.push_back(seq++);
          end else begin
            m_set = 1;
          end
        end
        if (m_phase == 1 && m_a2 == 1) begin
          m_phase = 2;
          m_req = 0;
        end else if (m_phase == 2 && m_a2 == 0) begin
          m_phase = 0;
          m_done = 1;
        end
      end
      if (m_set != 0) m_ovf = 1;
      else if (clr_ovf) m_ovf = 0;
    end
  end

  // Monitor: per-cycle output comparison and done-to-event scoreboard.
  logic [7:0] dut_v, mod_v;
  always @(negedge clkHI) begin
    dut_v = {req_out, busy, pending, overflow, done};
    if (!rst) begin
      chk("reset_outputs", 32'(dut_v), 32'd0);
    end else begin
      mod_v = {m_req[0], (m_phase != 0), m_pend[CNT_W-1:0], m_ovf[0], m_done[0]};
      chk("cycle_outputs", 32'(dut_v), 32'(mod_v));
      if (done === 1'b1) begin
        chk("done_has_event", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        n_done++;
      end
    end
  end

  // clkLOW path model: ack follows req through a 3-cycle delay.
  int mode = 0;
  logic [2:0] rdly = '0;
  always @(negedge clkHI) rdly = {rdly[1:0], req_out};
  always @(posedge clkHI) begin
    #1;
    if (mode == 1) ack_in = rdly[2];
  end

  task automatic cyc(input bit p, input bit c);
    pulse_in = p;
    clr_ovf = c;
    @(posedge clkHI);
    #1;
    pulse_in = 1'b0;
    clr_ovf = 1'b0;
  endtask

  task automatic wait_idle(input string nm);
    int k;
    k = 0;
    while (!(m_phase == 0 && m_pend == 0) && k < 3000) begin
      cyc(1'b0, 1'b0);
      k++;
    end
    chk(nm, 32'(k < 3000), 32'd1);
    repeat (5) cyc(1'b0, 1'b0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int d0, seen, k;

  initial begin
    rst = 1'b0;
    pulse_in = 1'b1;
    ack_in = 1'b1;
    repeat (3) @(posedge clkHI);
    #1;
    chk("reset_req", 32'(req_out), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    rst = 1'b1;
    @(posedge clkHI);
    #1;
    chk("post_reset_launch", 32'(req_out), 32'd1);
    pulse_in = 1'b0;
    ack_in = 1'b0;
    mode = 1;
    wait_idle("drain_after_reset");

    // Single event with looped-back ack.
    d0 = n_done;
    cyc(1'b1, 1'b0);
    chk("single_req_rise", 32'(req_out), 32'd1);
    chk("single_pend", 32'(pending), 32'd0);
    wait_idle("single_drain");
    chk("single_done_count", 32'(n_done - d0), 32'd1);

    // Burst of five.
    d0 = n_done;
    for (int i = 0; i < 5; i++) begin
      cyc(1'b1, 1'b0);
      chk("burst_pend", 32'(pending), 32'(i));
      chk("burst_req", 32'(req_out), 32'd1);
    end
    wait_idle("burst_drain");
    chk("burst_done_count", 32'(n_done - d0), 32'd5);
    chk("burst_pend_end", 32'(pending), 32'd0);

    // Saturation with ack held low.
    mode = 0;
    ack_in = 1'b0;
    for (int i = 0; i < 16; i++) cyc(1'b1, 1'b0);
    chk("sat_pend", 32'(pending), 32'(MAXP));
    chk("sat_no_ovf_yet", 32'(overflow), 32'd0);
    cyc(1'b1, 1'b0);
    chk("sat_ovf_set", 32'(overflow), 32'd1);
    chk("sat_pend_hold", 32'(pending), 32'(MAXP));
    cyc(1'b0, 1'b1);
    chk("ovf_clear", 32'(overflow), 32'd0);
    cyc(1'b1, 1'b1);
    chk("ovf_set_wins", 32'(overflow), 32'd1);
    cyc(1'b0, 1'b1);
    mode = 1;
    wait_idle("sat_drain");

    // Reset in the middle of a handshake.
    mode = 0;
    ack_in = 1'b0;
    for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0);
    chk("mid_pend_before", 32'(pending), 32'd3);
    chk("mid_busy_before", 32'(busy), 32'd1);
    #1;
    rst = 1'b0;
    #1;
    chk("mid_rst_req", 32'(req_out), 32'd0);
    chk("mid_rst_pend", 32'(pending), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    d0 = n_done;
    repeat (2) @(posedge clkHI);
    #1;
    rst = 1'b1;
    mode = 1;
    repeat (20) cyc(1'b0, 1'b0);
    chk("mid_rst_no_done", 32'(n_done - d0), 32'd0);

    // Pulse coinciding with an IDLE launch while two events are queued.
    mode = 0;
    ack_in = 1'b0;
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0);
    ack_in = 1'b1;
    k = 0;
    while (m_phase != 2 && k < 50) begin
      cyc(1'b0, 1'b0);
      k++;
    end
    ack_in = 1'b0;
    seen = 0;
    k = 0;
    while (seen == 0 && k < 50) begin
      if (m_phase == 0 && m_pend == 2) begin
        cyc(1'b1, 1'b0);
        chk("simul_pend", 32'(pending), 32'd2);
        chk("simul_req", 32'(req_out), 32'd1);
        seen = 1;
      end else begin
        cyc(1'b0, 1'b0);
      end
      k++;
    end
    chk("simul_reached", 32'(seen), 32'd1);
    mode = 1;
    wait_idle("simul_drain");

    // Randomized traffic with bursty density.
    for (int blk = 0; blk < 15; blk++) begin
      int dens;
      dens = $urandom_range(1, 6);
      for (int i = 0; i < 100; i++) begin
        cyc(1'($urandom_range(0, dens) == 0), 1'($urandom_range(0, 15) == 0));
      end
    end
    wait_idle("random_drain");
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
